// File: rtl/soc_pio_pkg.sv
// soc_pio_pkg: register addresses and edge-type codes shared by the PIO input port
package soc_pio_pkg;
    typedef enum logic [1:0] {
        PIO_ADDR_DATA = 2'd0,
        PIO_ADDR_RSVD = 2'd1,
        PIO_ADDR_MASK = 2'd2,
        PIO_ADDR_EDGE = 2'd3
    } pio_addr_e;
    localparam int PIO_EDGE_RISE = 0;
    localparam int PIO_EDGE_FALL = 1;
    localparam int PIO_EDGE_ANY  = 2;
endpackage

// File: rtl/soc_keys_in_if.sv
// soc_keys_in_if: Avalon-MM slave bus bundle for the key/switch input port
interface soc_keys_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_pio_in_filter.sv
// soc_pio_in_filter: per-bit synchronizer chain with optional debounce
module soc_pio_in_filter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    logic [SYNC_STAGES-1:0] chain;
    logic sync;
    assign sync = chain[SYNC_STAGES-1];
    always_ff @(posedge clk) begin
        if (reset) chain <= '0;
        else chain <= {chain[SYNC_STAGES-2:0], raw};
    end
    if (DEBOUNCE_CYCLES == 0) begin : g_direct
        assign stable = sync;
    end else begin : g_debounce
        localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
        logic [CW-1:0] cnt;
        // LAST is one below the target because the accepting cycle is itself counted
        always_ff @(posedge clk) begin
            if (reset) begin
                stable <= 1'b0;
                cnt    <= '0;
            end else if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/soc_keys_in.sv
// soc_keys_in: Avalon-MM input port with edge capture and maskable level interrupt
module soc_keys_in
    import soc_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    soc_keys_in_if.slave     bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIMED = PW'(SYNC_STAGES + 1);
    logic [WIDTH-1:0] stable, stable_d, mask, capture, evt, clear;
    logic [PW-1:0] prime;
    logic wr, armed, unused;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        soc_pio_in_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_filter (
            .clk(clk),
            .reset(reset),
            .raw(in_port[i]),
            .stable(stable[i])
        );
    end
    assign wr     = bus.chipselect && !bus.write_n;
    assign armed  = prime == PRIMED;
    assign unused = ^bus.writedata;
    assign irq    = |(capture & mask);
    always_comb begin
        evt = EDGE_TYPE == PIO_EDGE_RISE ? stable & ~stable_d :
              EDGE_TYPE == PIO_EDGE_FALL ? ~stable & stable_d : stable ^ stable_d;
        clear = wr && bus.address == PIO_ADDR_EDGE ? bus.writedata[WIDTH-1:0] : '0;
        bus.readdata = bus.address == PIO_ADDR_DATA ? 32'(stable) :
                       bus.address == PIO_ADDR_MASK ? 32'(mask) :
                       bus.address == PIO_ADDR_EDGE ? 32'(capture) : '0;
    end
    // Events stay blocked until the synchronizers have flushed their reset zeros
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d <= '0;
            prime    <= '0;
            mask     <= '0;
            capture  <= '0;
        end else begin
            stable_d <= stable;
            if (!armed) prime <= prime + 1'b1;
            if (wr && bus.address == PIO_ADDR_MASK) mask <= bus.writedata[WIDTH-1:0];
            capture <= (capture & ~clear) | (armed ? evt : '0);
        end
    end
endmodule
